// File: rtl/score_keeper.sv
// Match controller: goal edge detection, saturating scores and the SERVE/PLAY/OVER sequence.
// Optional AUTO_RESTART_EN: leave OVER automatically after OVER_FRAMES animate strobes.
`timescale 1ns/1ps

module score_keeper #(
    parameter logic [3:0] WIN_SCORE    = 4'd9,
    parameter logic [7:0] SERVE_FRAMES = 8'd60,
    parameter logic [7:0] OVER_FRAMES  = 8'd180
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_animate,
    input  logic       i_goal_player_1,
    input  logic       i_goal_player_2,
    input  logic       i_restart,
    output logic [3:0] o_score_player_1,
    output logic [3:0] o_score_player_2,
    output logic       o_serve_hold,
    output logic       o_game_over,
    output logic [1:0] o_winner
);

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        PLAY  = 2'd1,
        OVER  = 2'd2
    } state_t;

    state_t     state, state_next;
    logic [7:0] cnt, cnt_next;
    logic [3:0] score_1_next, score_2_next;
    logic [1:0] winner_next;
    logic       g1_q, g2_q;
    logic       g1_rise, g2_rise;
    logic       restart;

    // Parameter values outside the legal ranges would break BCD display or the frame timing.
    if (WIN_SCORE == 4'd0 || WIN_SCORE > 4'd9) begin : g_bad_win
        $error("WIN_SCORE must be in 1..9");
    end
    if (SERVE_FRAMES == 8'd0 || OVER_FRAMES == 8'd0) begin : g_bad_frames
        $error("SERVE_FRAMES and OVER_FRAMES must be non-zero");
    end

    assign g1_rise = i_goal_player_1 & ~g1_q;
    assign g2_rise = i_goal_player_2 & ~g2_q;

    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        score_1_next = o_score_player_1;
        score_2_next = o_score_player_2;
        winner_next  = o_winner;
        restart      = 1'b0;

        case (state)
            SERVE: begin
                if (i_animate) begin
                    if (cnt == SERVE_FRAMES - 8'd1) begin
                        state_next = PLAY;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 8'd1;
                    end
                end
            end

            PLAY: begin
                cnt_next = '0;
                if (g1_rise && g2_rise) begin
                    state_next = SERVE;
                end else if (g1_rise) begin
                    if (o_score_player_1 >= WIN_SCORE - 4'd1) begin
                        score_1_next = WIN_SCORE;
                        winner_next  = 2'b01;
                        state_next   = OVER;
                    end else begin
                        score_1_next = o_score_player_1 + 4'd1;
                        state_next   = SERVE;
                    end
                end else if (g2_rise) begin
                    if (o_score_player_2 >= WIN_SCORE - 4'd1) begin
                        score_2_next = WIN_SCORE;
                        winner_next  = 2'b10;
                        state_next   = OVER;
                    end else begin
                        score_2_next = o_score_player_2 + 4'd1;
                        state_next   = SERVE;
                    end
                end
            end

            OVER: begin
`ifdef AUTO_RESTART_EN
                if (i_restart || (i_animate && cnt == OVER_FRAMES - 8'd1)) begin
                    restart = 1'b1;
                end else if (i_animate) begin
                    cnt_next = cnt + 8'd1;
                end
`else
                restart  = i_restart;
                cnt_next = '0;
`endif
                if (restart) begin
                    score_1_next = '0;
                    score_2_next = '0;
                    winner_next  = 2'b00;
                    cnt_next     = '0;
                    state_next   = SERVE;
                end
            end

            default: begin
                state_next = SERVE;
                cnt_next   = '0;
            end
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state            <= SERVE;
            cnt              <= '0;
            o_score_player_1 <= '0;
            o_score_player_2 <= '0;
            o_winner         <= 2'b00;
            o_serve_hold     <= 1'b1;
            o_game_over      <= 1'b0;
            g1_q             <= 1'b0;
            g2_q             <= 1'b0;
        end else begin
            state            <= state_next;
            cnt              <= cnt_next;
            o_score_player_1 <= score_1_next;
            o_score_player_2 <= score_2_next;
            o_winner         <= winner_next;
            // Hold and game-over are registered from the next state so they align with it.
            o_serve_hold     <= (state_next != PLAY);
            o_game_over      <= (state_next == OVER);
            g1_q             <= i_goal_player_1;
            g2_q             <= i_goal_player_2;
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: match-level model compared every cycle plus literal checks.
// Follows the RTL's AUTO_RESTART_EN setting when the same macro is defined for the bench.
`timescale 1ns/1ps

module tb_score_keeper;

    localparam int WIN   = 9;
    localparam int SERVE = 60;
    localparam int OVERF = 180;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_animate = 1'b0;
    logic       i_goal_player_1 = 1'b0;
    logic       i_goal_player_2 = 1'b0;
    logic       i_restart = 1'b0;
    logic [3:0] o_score_player_1;
    logic [3:0] o_score_player_2;
    logic       o_serve_hold;
    logic       o_game_over;
    logic [1:0] o_winner;

    int n_compared   = 0;
    int n_mismatched = 0;

    score_keeper dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_animate        (i_animate),
        .i_goal_player_1  (i_goal_player_1),
        .i_goal_player_2  (i_goal_player_2),
        .i_restart        (i_restart),
        .o_score_player_1 (o_score_player_1),
        .o_score_player_2 (o_score_player_2),
        .o_serve_hold     (o_serve_hold),
        .o_game_over      (o_game_over),
        .o_winner         (o_winner)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Match-level model: scores as integers, a "ball in play" flag and frame tallies.
    int m_s1, m_s2, m_winner, m_serve_seen, m_over_seen;
    bit m_play, m_over, m_p1, m_p2, m_valid = 1'b0;

    always @(posedge i_clk) begin
        bit r1, r2, leave_over;
        if (i_rst) begin
            m_s1 = 0; m_s2 = 0; m_winner = 0;
            m_serve_seen = 0; m_over_seen = 0;
            m_play = 0; m_over = 0; m_p1 = 0; m_p2 = 0;
            m_valid = 1'b1;
        end else begin
            r1 = i_goal_player_1 && !m_p1;
            r2 = i_goal_player_2 && !m_p2;
            if (m_over) begin
                leave_over = i_restart;
`ifdef AUTO_RESTART_EN
                if (i_animate) begin
                    m_over_seen++;
                    if (m_over_seen == OVERF) leave_over = 1'b1;
                end
`endif
                if (leave_over) begin
                    m_s1 = 0; m_s2 = 0; m_winner = 0;
                    m_over = 0; m_serve_seen = 0; m_over_seen = 0;
                end
            end else if (!m_play) begin
                if (i_animate) begin
                    m_serve_seen++;
                    if (m_serve_seen == SERVE) begin
                        m_play = 1; m_serve_seen = 0;
                    end
                end
            end else if (r1 || r2) begin
                m_play = 0;
                if (r1 && !r2) m_s1 = (m_s1 + 1 > WIN) ? WIN : m_s1 + 1;
                if (r2 && !r1) m_s2 = (m_s2 + 1 > WIN) ? WIN : m_s2 + 1;
                if (m_s1 == WIN) begin m_over = 1; m_winner = 1; m_over_seen = 0; end
                if (m_s2 == WIN) begin m_over = 1; m_winner = 2; m_over_seen = 0; end
            end
            m_p1 = i_goal_player_1;
            m_p2 = i_goal_player_2;
        end
    end

    always @(negedge i_clk) begin
        if (m_valid) begin
            check("cycle", {o_score_player_1, o_score_player_2, o_serve_hold, o_game_over, o_winner},
                  {4'(m_s1), 4'(m_s2), ~m_play, m_over, 2'(m_winner)});
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic animate_ticks(input int n);
        i_animate = 1'b1;
        repeat (n) tick();
        i_animate = 1'b0;
    endtask

    task automatic score_point(input int player);
        animate_ticks(SERVE);
        if (player == 1) i_goal_player_1 = 1'b1; else i_goal_player_2 = 1'b1;
        tick();
        i_goal_player_1 = 1'b0;
        i_goal_player_2 = 1'b0;
        tick();
    endtask

    function automatic logic [11:0] outs();
        return {o_score_player_1, o_score_player_2, o_serve_hold, o_game_over, o_winner};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) tick();
        i_rst = 1'b0;
        check("reset_state", outs(), {4'd0, 4'd0, 1'b1, 1'b0, 2'b00});

        // 59 frames keep the ball held, the 60th releases it.
        animate_ticks(SERVE - 1);
        check("hold_after_59", {11'd0, o_serve_hold}, 12'd1);
        animate_ticks(1);
        check("play_after_60", {11'd0, o_serve_hold}, 12'd0);

        // A goal level held for 500 cycles scores once.
        i_goal_player_1 = 1'b1;
        tick();
        check("held_goal_first", outs(), {4'd1, 4'd0, 1'b1, 1'b0, 2'b00});
        repeat (499) tick();
        check("held_goal_500", outs(), {4'd1, 4'd0, 1'b1, 1'b0, 2'b00});
        i_goal_player_1 = 1'b0;
        tick();

        // Simultaneous rise replays the point.
        animate_ticks(SERVE);
        i_goal_player_1 = 1'b1;
        i_goal_player_2 = 1'b1;
        tick();
        check("replay", outs(), {4'd1, 4'd0, 1'b1, 1'b0, 2'b00});
        i_goal_player_1 = 1'b0;
        i_goal_player_2 = 1'b0;
        tick();

        // Player 2 runs to nine.
        for (int i = 0; i < WIN; i++) score_point(2);
        check("p2_wins", outs(), {4'd1, 4'd9, 1'b1, 1'b1, 2'b10});
        i_goal_player_2 = 1'b1;
        tick();
        i_goal_player_2 = 1'b0;
        tick();
        check("over_saturate", outs(), {4'd1, 4'd9, 1'b1, 1'b1, 2'b10});

        i_restart = 1'b1;
        tick();
        i_restart = 1'b0;
        check("manual_restart", outs(), {4'd0, 4'd0, 1'b1, 1'b0, 2'b00});

        // Build 3:5, then restart is ignored mid-play and reset clears everything.
        for (int i = 0; i < 3; i++) score_point(1);
        for (int i = 0; i < 5; i++) score_point(2);
        animate_ticks(SERVE);
        i_restart = 1'b1;
        tick();
        i_restart = 1'b0;
        check("restart_ignored", outs(), {4'd3, 4'd5, 1'b0, 1'b0, 2'b00});
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("reset_mid_play", outs(), {4'd0, 4'd0, 1'b1, 1'b0, 2'b00});
        animate_ticks(SERVE - 1);
        check("cnt_cleared_59", {11'd0, o_serve_hold}, 12'd1);
        animate_ticks(1);
        check("cnt_cleared_60", {11'd0, o_serve_hold}, 12'd0);

        // Player 1 runs to nine.
        for (int i = 0; i < WIN; i++) score_point(1);
        check("p1_wins", outs(), {4'd9, 4'd0, 1'b1, 1'b1, 2'b01});

`ifdef AUTO_RESTART_EN
        animate_ticks(OVERF - 1);
        check("auto_before", outs(), {4'd9, 4'd0, 1'b1, 1'b1, 2'b01});
        animate_ticks(1);
        check("auto_restart", outs(), {4'd0, 4'd0, 1'b1, 1'b0, 2'b00});
`else
        animate_ticks(OVERF + 20);
        check("no_auto_restart", outs(), {4'd9, 4'd0, 1'b1, 1'b1, 2'b01});
        i_restart = 1'b1;
        tick();
        i_restart = 1'b0;
        check("late_restart", outs(), {4'd0, 4'd0, 1'b1, 1'b0, 2'b00});
`endif
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
